// File: rtl/vport_pkg.sv
// Shared constants for the virtual-port console: default port decode and TX state encoding.
package vport_pkg;

    localparam logic [13:0] VPORT_ADDR_DEF = 14'h1fff;
    localparam logic [7:0]  HALT_CHAR_DEF  = 8'hff;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t ST_IDLE  = 2'd0;
    localparam tx_state_t ST_START = 2'd1;
    localparam tx_state_t ST_DATA  = 2'd2;
    localparam tx_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/vport_fifo.sv
// Synchronous byte FIFO; a push written at an edge is visible on pop_data from the next cycle.
// Full FIFO accepts a push only when a pop happens in the same cycle; otherwise push_ok stays low.
module vport_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       push_ok,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       empty,
    output logic       full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign push_ok  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/vport_uart_tx.sv
// Console port: snoops data_ram byte writes to VPORT_ADDR and sends them as 8N1 frames on uart_txd.
// txd falls two cycles after the write edge; bytes arriving with the FIFO full are dropped (overflow).
module vport_uart_tx
    import vport_pkg::*;
#(
    parameter logic [13:0] VPORT_ADDR = VPORT_ADDR_DEF,
    parameter logic [7:0]  HALT_CHAR  = HALT_CHAR_DEF,
    parameter int          CLK_DIV    = 434,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [13:0] ram_addra,
    input  logic [3:0]  ram_wea,
    input  logic [31:0] ram_dina,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic        overflow,
    output logic        halt
);

    localparam int             CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          halt_pending;

    logic          hit;
    logic          is_halt;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;
    logic          fifo_full;
    logic          cnt_end;
    logic          unused_dina_hi;

    // Only the low byte of the write data carries the character.
    assign unused_dina_hi = ^ram_dina[31:8];

    assign hit     = (ram_addra == VPORT_ADDR) && (|ram_wea);
    assign is_halt = (ram_dina[7:0] == HALT_CHAR);
    assign push    = hit && !is_halt && !halt_pending;
    assign cnt_end = (cnt == CNT_LAST);

    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE: pop = !fifo_empty;
            ST_STOP: pop = cnt_end && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    vport_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (ram_dina[7:0]),
        .push_ok   (push_ok),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shreg <= fifo_dout;
                        cnt   <= '0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_end) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_end) begin
                        cnt <= '0;
                        if (idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // Chain straight into the next start bit when more bytes are waiting.
                    if (cnt_end) begin
                        cnt <= '0;
                        if (!fifo_empty) begin
                            shreg <= fifo_dout;
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // txd is a register that follows the FSM by one cycle, so it never glitches.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            uart_txd     <= 1'b1;
            tx_busy      <= 1'b0;
            overflow     <= 1'b0;
            halt         <= 1'b0;
            halt_pending <= 1'b0;
        end else begin
            case (state)
                ST_START: uart_txd <= 1'b0;
                ST_DATA:  uart_txd <= shreg[idx];
                default:  uart_txd <= 1'b1;
            endcase
            tx_busy <= (state != ST_IDLE) || !fifo_empty;
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (hit && is_halt) begin
                halt_pending <= 1'b1;
            end
            if (halt_pending && fifo_empty && (state == ST_IDLE)) begin
                halt <= 1'b1;
            end
        end
    end

endmodule
